// File: rtl/dd_hiscore_xfer_if.sv
// dd_hiscore_xfer_if: start/status, core high-score port and save-buffer port of the transfer engine
interface dd_hiscore_xfer_if;
  logic        START_DUMP;
  logic        START_LOAD;
  logic        BUSY;
  logic        DONE;
  logic        PAUSE_REQ;
  logic [10:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_write;
  logic        hs_access;
  logic [10:0] BUF_AD;
  logic        BUF_WR;
  logic [7:0]  BUF_DO;
  logic [7:0]  BUF_DI;
  logic [7:0]  CSUM;
  modport master (
    input  START_DUMP, START_LOAD, hs_data_out, BUF_DI,
    output BUSY, DONE, PAUSE_REQ, hs_address, hs_data_in, hs_write, hs_access,
           BUF_AD, BUF_WR, BUF_DO, CSUM
  );
  modport slave (
    output START_DUMP, START_LOAD, hs_data_out, BUF_DI,
    input  BUSY, DONE, PAUSE_REQ, hs_address, hs_data_in, hs_write, hs_access,
           BUF_AD, BUF_WR, BUF_DO, CSUM
  );
endinterface

// File: rtl/dd_hiscore_xfer.sv
// dd_hiscore_xfer: copies the high-score region between core RAM and the save buffer; DD_HS_CHECKSUM_EN adds a byte checksum on CSUM
module dd_hiscore_xfer #(
  parameter logic [10:0] HS_BASE   = 11'h000,
  parameter int          HS_LEN    = 64,
  parameter int          RD_LAT    = 2,
  parameter int          PAUSE_DLY = 16
) (
  input logic             MCLK,
  input logic             RESET,
  dd_hiscore_xfer_if.master hs
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;
  logic [2:0]  r_st;
  logic        r_load;
  logic [10:0] r_idx;
  logic [15:0] r_cnt;
  logic [7:0]  r_byte;
  logic [7:0]  w_src;
  logic        w_act;
  logic        w_wr;
  assign w_src = r_load ? hs.BUF_DI : hs.hs_data_out;
  // sequencer: settle delay, then address / wait latency / write / advance per byte
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_st   <= S_IDLE;
      r_load <= 1'b0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_byte <= '0;
    end else begin
      case (r_st)
        S_IDLE:
          if (hs.START_DUMP || hs.START_LOAD) begin
            r_load <= !hs.START_DUMP;
            r_idx  <= '0;
            r_cnt  <= 16'(PAUSE_DLY);
            r_st   <= S_SETTLE;
          end
        S_SETTLE:
          if (r_cnt == 16'd0) r_st <= S_ADDR;
          else r_cnt <= r_cnt - 16'd1;
        S_ADDR: begin
          r_cnt <= 16'(RD_LAT);
          r_st  <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            r_byte <= w_src;
            r_st   <= S_WRITE;
          end
        end
        S_WRITE: r_st <= S_NEXT;
        S_NEXT:
          if (r_idx == 11'(HS_LEN - 1)) r_st <= S_FIN;
          else begin
            r_idx <= r_idx + 11'd1;
            r_st  <= S_ADDR;
          end
        default: r_st <= S_IDLE;
      endcase
    end
  end
`ifdef DD_HS_CHECKSUM_EN
  logic [7:0] r_sum;
  // running sum of every captured source byte, cleared on each accepted start
  always_ff @(posedge MCLK) begin
    if (RESET) r_sum <= '0;
    else if (r_st == S_IDLE && (hs.START_DUMP || hs.START_LOAD)) r_sum <= '0;
    else if (r_st == S_WAIT && r_cnt == 16'd1) r_sum <= r_sum + w_src;
  end
  assign hs.CSUM = r_sum;
`else
  assign hs.CSUM = '0;
`endif
  assign w_act         = r_st == S_ADDR || r_st == S_WAIT || r_st == S_WRITE;
  assign w_wr          = r_st == S_WRITE;
  assign hs.BUSY       = r_st != S_IDLE;
  assign hs.PAUSE_REQ  = r_st != S_IDLE;
  assign hs.DONE       = r_st == S_FIN;
  assign hs.hs_access  = w_act;
  assign hs.hs_address = w_act ? HS_BASE + r_idx : '0;
  assign hs.BUF_AD     = w_act ? r_idx : '0;
  assign hs.hs_write   = w_wr && r_load;
  assign hs.hs_data_in = (w_wr && r_load) ? r_byte : '0;
  assign hs.BUF_WR     = w_wr && !r_load;
  assign hs.BUF_DO     = (w_wr && !r_load) ? r_byte : '0;
endmodule

// File: tb/tb_dd_hiscore_xfer.sv
// tb_dd_hiscore_xfer: timeline model of the transfer engine over four parameter sets
module tb_dd_hiscore_xfer;
  localparam logic [10:0] C_BASE [4] = '{11'h000, 11'h7FE, 11'h123, 11'h050};
  localparam int          C_LEN  [4] = '{4, 4, 3, 1};
  localparam int          C_LAT  [4] = '{2, 1, 7, 3};
  localparam int          C_PD   [4] = '{16, 3, 2, 1};
`ifdef DD_HS_CHECKSUM_EN
  localparam logic [7:0] CS_DUMP = 8'hAA;
  localparam logic [7:0] CS_LOAD = 8'h05;
`else
  localparam logic [7:0] CS_DUMP = 8'h00;
  localparam logic [7:0] CS_LOAD = 8'h00;
`endif
  logic       clk = 1'b0;
  logic [3:0] sd, sl, rs;
  logic [3:0] dn, bz, pq, ac;
  logic [7:0] cs [4];
  bit         go = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s @%0t: got %h expected %h", g, nm, $time, act, exp);
    end
  endtask
  for (genvar g = 0; g < 4; g++) begin : u
    localparam logic [10:0] BASE = C_BASE[g];
    localparam int LEN = C_LEN[g];
    localparam int L   = C_LAT[g];
    localparam int PD  = C_PD[g];
    localparam int F   = PD + 2 + LEN * (L + 3);
    dd_hiscore_xfer_if bus ();
    dd_hiscore_xfer #(.HS_BASE(BASE), .HS_LEN(LEN), .RD_LAT(L), .PAUSE_DLY(PD)) dut (
      .MCLK(clk), .RESET(rs[g]), .hs(bus)
    );
    logic [7:0]  core [2048];
    logic [7:0]  bufm [2048];
    logic        pa;
    logic        rp [8];
    logic [10:0] ap [8];
    logic [10:0] bp [8];
    logic [10:0] aq [16];
    int          sc [16];
    int          e = 0, m_c = 0, nw = 0, nbw = 0, nd = 0, na = 0, ns = 0;
    bit          m_busy = 0, m_load = 0, m_csv = 1;
    logic [7:0]  m_cs = 0;
    assign bus.START_DUMP  = sd[g];
    assign bus.START_LOAD  = sl[g];
    assign bus.hs_data_out = rp[L-1] ? core[ap[L-1]] : 8'h5A;
    assign bus.BUF_DI      = rp[L-1] ? bufm[bp[L-1]] : 8'hA5;
    assign dn[g] = bus.DONE;
    assign bz[g] = bus.BUSY;
    assign pq[g] = bus.PAUSE_REQ;
    assign ac[g] = bus.hs_access;
    assign cs[g] = bus.CSUM;
    initial begin
      for (int i = 0; i < 2048; i++) begin
        core[i] = 8'(i * 37 + 5);
        bufm[i] = 8'(i * 91 + 17);
      end
      if (g == 0) begin
        core[0] = 8'h11; core[1] = 8'h22; core[2] = 8'h33; core[3] = 8'h44;
      end
    end
    // source side: data appears exactly L cycles after an access begins, garbage otherwise
    always @(posedge clk) begin
      pa    <= bus.hs_access;
      rp[0] <= bus.hs_access && !pa;
      ap[0] <= bus.hs_address;
      bp[0] <= bus.BUF_AD;
      for (int k = 1; k < 8; k++) begin
        rp[k] <= rp[k-1];
        ap[k] <= ap[k-1];
        bp[k] <= bp[k-1];
      end
    end
    // sinks, logs and the transfer timeline model
    always @(posedge clk) begin : mdl
      bit idle_prev;
      int s;
      if (bus.hs_write) begin core[bus.hs_address] = bus.hs_data_in; nw++; end
      if (bus.BUF_WR) begin bufm[bus.BUF_AD] = bus.BUF_DO; nbw++; end
      if (bus.DONE) nd++;
      if (bus.hs_access && !pa && na < 16) begin aq[na] = bus.hs_address; na++; end
      if ((bus.hs_write || bus.BUF_WR) && ns < 16) begin sc[ns] = e; ns++; end
      e++;
      if (rs[g]) begin
        m_busy = 0; m_csv = 1; m_cs = 0;
      end else begin
        idle_prev = !m_busy;
        if (m_busy && e - 1 - m_c == F) begin m_busy = 0; m_csv = 1; end
        if (idle_prev && (sd[g] || sl[g])) begin
          m_busy = 1; m_c = e - 1; m_load = !sd[g]; m_csv = 0; s = 0;
          for (int i = 0; i < LEN; i++) s += m_load ? int'(bufm[i]) : int'(core[11'(BASE + i)]);
`ifdef DD_HS_CHECKSUM_EN
          m_cs = 8'(s);
`else
          m_cs = 8'(s & 0);
`endif
        end
      end
    end
    // every cycle: all outputs against the model's timeline
    always @(negedge clk) begin : cmp
      int o, b, i, p;
      logic busy, done, acc, hw, bw;
      logic [10:0] ha, ba;
      logic [7:0] hd, bd;
      if (go) begin
        o = 0; busy = 0; done = 0; acc = 0; hw = 0; bw = 0; ha = 0; ba = 0; hd = 0; bd = 0;
        if (m_busy) begin
          o = e - m_c; busy = 1; done = o == F;
          if (o >= PD + 2 && o < F) begin
            b = o - PD - 2; i = b / (L + 3); p = b % (L + 3);
            if (p <= L + 1) begin acc = 1; ha = 11'(BASE + i); ba = 11'(i); end
            if (p == L + 1) begin
              if (m_load) begin hw = 1; hd = bufm[i]; end
              else begin bw = 1; bd = core[11'(BASE + i)]; end
            end
          end
        end
        chk(g, "outs", {busy, done, busy, acc, hw, bw, ha, hd, ba, bd},
            {bus.BUSY, bus.DONE, bus.PAUSE_REQ, bus.hs_access, bus.hs_write, bus.BUF_WR,
             bus.hs_address, bus.hs_data_in, bus.BUF_AD, bus.BUF_DO});
        if (m_csv || (m_busy && o == F)) chk(g, "csum", bus.CSUM, m_cs);
      end
    end
  end
  task automatic start(input int g, input logic d, input logic l);
    sd[g] = d; sl[g] = l;
    @(negedge clk);
    sd[g] = 1'b0; sl[g] = 1'b0;
  endtask
  task automatic wait_done(input int g, input int lim, output int lat);
    lat = 1;
    while (!dn[g] && lat < lim) begin
      @(negedge clk);
      lat++;
    end
    if (!dn[g]) chk(g, "done_timeout", 64'(dn[g]), 64'd1);
  endtask
  initial begin
    logic [7:0]  ex_d [4];
    logic [7:0]  ex_l [4];
    logic [10:0] ex_a [4];
    int lat, n0;
    ex_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    ex_l = '{8'h01, 8'h02, 8'h03, 8'hFF};
    ex_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    sd = '0; sl = '0; rs = '1;
    repeat (3) @(negedge clk);
    go = 1'b1;
    chk(0, "rst_busy", 64'(bz[0]), 64'd0);
    chk(0, "rst_pause", 64'(pq[0]), 64'd0);
    chk(0, "rst_csum", 64'(cs[0]), 64'd0);
    rs = '0;
    @(negedge clk);
    u[0].ns = 0;
    start(0, 1'b1, 1'b0);
    wait_done(0, 200, lat);
    chk(0, "dump_lat", 64'(lat), 64'd38);
    chk(0, "dump_csum", 64'(cs[0]), 64'(CS_DUMP));
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk(0, "dump_buf", 64'(u[0].bufm[i]), 64'(ex_d[i]));
    chk(0, "dump_spacing", 64'(u[0].sc[1] - u[0].sc[0]), 64'd5);
    for (int i = 0; i < 4; i++) u[0].bufm[i] = ex_l[i];
    n0 = u[0].nbw;
    start(0, 1'b0, 1'b1);
    wait_done(0, 200, lat);
    chk(0, "load_lat", 64'(lat), 64'd38);
    chk(0, "load_csum", 64'(cs[0]), 64'(CS_LOAD));
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk(0, "load_core", 64'(u[0].core[i]), 64'(ex_l[i]));
    chk(0, "load_no_bufwr", 64'(u[0].nbw - n0), 64'd0);
    u[0].nd = 0; n0 = u[0].nbw;
    start(0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    start(0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    chk(0, "both_one_done", 64'(u[0].nd), 64'd1);
    chk(0, "both_is_dump", 64'(u[0].nbw - n0), 64'd4);
    u[0].nw = 0; u[0].nd = 0;
    start(0, 1'b0, 1'b1);
    repeat (28) @(negedge clk);
    rs[0] = 1'b1;
    @(negedge clk);
    rs[0] = 1'b0;
    chk(0, "abort_busy", 64'(bz[0]), 64'd0);
    chk(0, "abort_pause", 64'(pq[0]), 64'd0);
    chk(0, "abort_access", 64'(ac[0]), 64'd0);
    repeat (50) @(negedge clk);
    chk(0, "abort_writes", 64'(u[0].nw), 64'd2);
    chk(0, "abort_no_done", 64'(u[0].nd), 64'd0);
    u[1].na = 0; u[1].ns = 0;
    start(1, 1'b1, 1'b0);
    wait_done(1, 200, lat);
    chk(1, "wrap_lat", 64'(lat), 64'd21);
    for (int i = 0; i < 4; i++) chk(1, "wrap_addr", 64'(u[1].aq[i]), 64'(ex_a[i]));
    chk(1, "lat1_spacing", 64'(u[1].sc[1] - u[1].sc[0]), 64'd4);
    chk(1, "lat1_spacing_end", 64'(u[1].sc[3] - u[1].sc[2]), 64'd4);
    repeat (3) @(negedge clk);
    u[2].ns = 0;
    start(2, 1'b0, 1'b1);
    wait_done(2, 200, lat);
    chk(2, "lat7_lat", 64'(lat), 64'd34);
    chk(2, "lat7_spacing", 64'(u[2].sc[1] - u[2].sc[0]), 64'd10);
    repeat (3) @(negedge clk);
    start(2, 1'b1, 1'b0);
    wait_done(2, 200, lat);
    chk(2, "lat7_dump_lat", 64'(lat), 64'd34);
    repeat (3) @(negedge clk);
    u[3].nd = 0;
    start(3, 1'b1, 1'b0);
    wait_done(3, 100, lat);
    chk(3, "len1_dump_lat", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);
    start(3, 1'b0, 1'b1);
    wait_done(3, 100, lat);
    chk(3, "len1_load_lat", 64'(lat), 64'd9);
    repeat (5) @(negedge clk);
    chk(3, "len1_dones", 64'(u[3].nd), 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
